// File: rtl/ddr_resp_pkg.sv
// rtl/ddr_resp_pkg.sv - FSM encodings, LFSR constants and beat width shared by the DDR AXI responder
package ddr_resp_pkg;

    localparam int DEF_MEM_DQ_WIDTH = 32;
    localparam int BEAT_W           = DEF_MEM_DQ_WIDTH * 8;

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_AW_ACK = 5'b00010,
        S_WDATA  = 5'b00100,
        S_AR_ACK = 5'b01000,
        S_RDATA  = 5'b10000
    } state_t;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ddr_axi_resp_mem_if.sv
// rtl/ddr_axi_resp_mem_if.sv - simplified DDR AXI burst bus between a traffic generator and the responder
interface ddr_axi_resp_mem_if
    import ddr_resp_pkg::*;
#(
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int BEAT_WIDTH      = BEAT_W
) ();

    logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr;
    logic [3:0]                 axi_awlen;
    logic                       axi_awvalid;
    logic                       axi_awready;
    logic [BEAT_WIDTH-1:0]      axi_wdata;
    logic                       axi_wready;
    logic                       axi_wusero_last;
    logic [CTRL_ADDR_WIDTH-1:0] axi_araddr;
    logic [3:0]                 axi_arlen;
    logic                       axi_arvalid;
    logic                       axi_arready;
    logic [BEAT_WIDTH-1:0]      axi_rdata;
    logic                       axi_rvalid;
    logic                       axi_rlast;
    logic [15:0]                wr_bursts;
    logic [15:0]                rd_bursts;

    modport master (
        output axi_awaddr, axi_awlen, axi_awvalid, axi_wdata, axi_araddr, axi_arlen, axi_arvalid,
        input  axi_awready, axi_wready, axi_wusero_last, axi_arready, axi_rdata, axi_rvalid, axi_rlast,
               wr_bursts, rd_bursts
    );

    modport slave (
        input  axi_awaddr, axi_awlen, axi_awvalid, axi_wdata, axi_araddr, axi_arlen, axi_arvalid,
        output axi_awready, axi_wready, axi_wusero_last, axi_arready, axi_rdata, axi_rvalid, axi_rlast,
               wr_bursts, rd_bursts
    );

endinterface

// File: rtl/ddr_resp_ram.sv
// rtl/ddr_resp_ram.sv - single-port beat RAM, synchronous write and registered read
module ddr_resp_ram #(
    parameter int DEPTH_AW = 6,
    parameter int DATA_W   = 256
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic                i_re,
    input  logic [DEPTH_AW-1:0] i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    output logic [DATA_W-1:0]   o_rdata
);

    logic [DATA_W-1:0] r_mem [2**DEPTH_AW];
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        if (i_re) r_q <= r_mem[i_addr];
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/ddr_axi_resp_mem.sv
// rtl/ddr_axi_resp_mem.sv - DDR AXI burst responder backed by a beat RAM; DDR_RESP_BP_EN adds LFSR data-phase stalls
module ddr_axi_resp_mem
    import ddr_resp_pkg::*;
#(
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int MEM_DQ_WIDTH    = DEF_MEM_DQ_WIDTH,
    parameter int DEPTH_AW        = 6,
    parameter int ADDR_LSB        = 3
) (
    input  logic              core_clk,
    input  logic              core_clk_rst_n,
    ddr_axi_resp_mem_if.slave axi
);

    localparam int BW = MEM_DQ_WIDTH * 8;

    state_t              r_state, w_state_nxt;
    logic [DEPTH_AW-1:0] r_base, w_base_nxt, w_ram_addr;
    logic [3:0]          r_len, w_len_nxt, r_cnt, w_cnt_nxt;
    logic                r_rd_done, w_rd_done_nxt;
    logic                r_awready, r_wready, r_wlast, r_arready, r_rvalid, r_rlast;
    logic                r_p_valid, r_p_last;
    logic [BW-1:0]       r_rdata, w_ram_q;
    logic [15:0]         r_wr_bursts, r_rd_bursts;
    logic                w_wbeat, w_rissue, w_wstall_nxt, w_rstall;
    logic                w_unused;

`ifdef DDR_RESP_BP_EN
    logic [7:0] r_lfsr, w_lfsr_nxt, w_lfsr_nxt2;
    assign w_lfsr_nxt  = lfsr_step(r_lfsr);
    assign w_lfsr_nxt2 = lfsr_step(w_lfsr_nxt);
    always_ff @(posedge core_clk) begin
        if (!core_clk_rst_n) r_lfsr <= LFSR_SEED;
        else                 r_lfsr <= w_lfsr_nxt;
    end
    assign w_wstall_nxt = w_lfsr_nxt[0];
    // read data surfaces two cycles after issue, so the issue decision looks two LFSR steps ahead
    assign w_rstall     = w_lfsr_nxt2[0];
`else
    assign w_wstall_nxt = 1'b0;
    assign w_rstall     = 1'b0;
`endif

    assign w_wbeat    = (r_state == S_WDATA) && r_wready;
    assign w_rissue   = (r_state == S_RDATA) && !r_rd_done && !w_rstall;
    assign w_ram_addr = r_base + DEPTH_AW'(r_cnt);
    assign w_unused   = ^{axi.axi_awaddr, axi.axi_araddr};

    always_comb begin
        w_state_nxt   = r_state;
        w_base_nxt    = r_base;
        w_len_nxt     = r_len;
        w_cnt_nxt     = r_cnt;
        w_rd_done_nxt = r_rd_done;
        unique case (r_state)
            S_IDLE: begin
                if (axi.axi_awvalid)      w_state_nxt = S_AW_ACK;
                else if (axi.axi_arvalid) w_state_nxt = S_AR_ACK;
            end
            S_AW_ACK: begin
                if (axi.axi_awvalid && r_awready) begin
                    w_base_nxt  = axi.axi_awaddr[ADDR_LSB+DEPTH_AW-1:ADDR_LSB];
                    w_len_nxt   = axi.axi_awlen;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WDATA;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WDATA: begin
                if (w_wbeat) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                    if (r_cnt == r_len) w_state_nxt = S_IDLE;
                end
            end
            S_AR_ACK: begin
                if (axi.axi_arvalid && r_arready) begin
                    w_base_nxt    = axi.axi_araddr[ADDR_LSB+DEPTH_AW-1:ADDR_LSB];
                    w_len_nxt     = axi.axi_arlen;
                    w_cnt_nxt     = '0;
                    w_rd_done_nxt = 1'b0;
                    w_state_nxt   = S_RDATA;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RDATA: begin
                if (w_rissue) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                    if (r_cnt == r_len) w_rd_done_nxt = 1'b1;
                end
                if (r_rvalid && r_rlast) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (!core_clk_rst_n) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_rd_done   <= 1'b0;
            r_awready   <= 1'b0;
            r_arready   <= 1'b0;
            r_wready    <= 1'b0;
            r_wlast     <= 1'b0;
            r_p_valid   <= 1'b0;
            r_p_last    <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rlast     <= 1'b0;
            r_rdata     <= '0;
            r_wr_bursts <= '0;
            r_rd_bursts <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_base    <= w_base_nxt;
            r_len     <= w_len_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rd_done <= w_rd_done_nxt;
            r_awready <= (w_state_nxt == S_AW_ACK);
            r_arready <= (w_state_nxt == S_AR_ACK);
            r_wready  <= (w_state_nxt == S_WDATA) && !w_wstall_nxt;
            r_wlast   <= (w_state_nxt == S_WDATA) && !w_wstall_nxt && (w_cnt_nxt == w_len_nxt);
            r_p_valid <= w_rissue;
            r_p_last  <= w_rissue && (r_cnt == r_len);
            r_rvalid  <= r_p_valid;
            r_rlast   <= r_p_last;
            if (r_p_valid) r_rdata <= w_ram_q;
            if (w_wbeat && (r_cnt == r_len)) r_wr_bursts <= r_wr_bursts + 16'd1;
            if (r_rvalid && r_rlast)         r_rd_bursts <= r_rd_bursts + 16'd1;
        end
    end

    // gating with reset keeps an interrupted burst from touching the RAM on the reset edge
    ddr_resp_ram #(.DEPTH_AW(DEPTH_AW), .DATA_W(BW)) u_ram (
        .i_clk   (core_clk),
        .i_we    (w_wbeat && core_clk_rst_n),
        .i_re    (w_rissue),
        .i_addr  (w_ram_addr),
        .i_wdata (axi.axi_wdata),
        .o_rdata (w_ram_q)
    );

    assign axi.axi_awready     = r_awready;
    assign axi.axi_wready      = r_wready;
    assign axi.axi_wusero_last = r_wlast;
    assign axi.axi_arready     = r_arready;
    assign axi.axi_rdata       = r_rdata;
    assign axi.axi_rvalid      = r_rvalid;
    assign axi.axi_rlast       = r_rlast;
    assign axi.wr_bursts       = r_wr_bursts;
    assign axi.rd_bursts       = r_rd_bursts;

endmodule

// File: tb/tb_ddr_axi_resp_mem.sv
// tb/tb_ddr_axi_resp_mem.sv - randomized bench for ddr_axi_resp_mem with a beat-array memory model
module tb_ddr_axi_resp_mem;

    localparam int AW    = 28;
    localparam int BW    = 256;
    localparam int DEPTH = 64;

    logic core_clk = 1'b0;
    logic core_clk_rst_n = 1'b0;
    always #5 core_clk = ~core_clk;

    ddr_axi_resp_mem_if #(.CTRL_ADDR_WIDTH(AW), .BEAT_WIDTH(BW)) axi ();

    ddr_axi_resp_mem #(.CTRL_ADDR_WIDTH(AW), .MEM_DQ_WIDTH(32), .DEPTH_AW(6), .ADDR_LSB(3)) dut (
        .core_clk       (core_clk),
        .core_clk_rst_n (core_clk_rst_n),
        .axi            (axi)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [BW-1:0] m_mem   [DEPTH];
    bit            m_known [DEPTH];
    logic [BW-1:0] wbuf    [16];
    int cur_wbase = 0, cur_wlen = 0, cur_rbase = 0, cur_rlen = 0;
    int w_seen = 0, r_seen = 0, exp_wr = 0, exp_rd = 0, mon_idx = 0;
    bit wr_pend = 0, rd_pend = 0, rst_pend = 0;
    logic [BW-1:0] first_rdata = '0, last_rdata = '0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge core_clk) begin
        if (!core_clk_rst_n) begin
            rst_pend = 1;
        end else if (rst_pend) begin
            rst_pend = 0;
            check("reset_outputs", {axi.axi_awready, axi.axi_wready, axi.axi_wusero_last, axi.axi_arready,
                                    axi.axi_rvalid, axi.axi_rlast, axi.wr_bursts, axi.rd_bursts}, '0);
            check("reset_rdata", axi.axi_rdata, '0);
            exp_wr = 0; exp_rd = 0; w_seen = 0; r_seen = 0; wr_pend = 0; rd_pend = 0;
        end else begin
            if (wr_pend) begin
                check("wready_after_last", axi.axi_wready, 0);
                exp_wr = (exp_wr + 1) % 65536;
                wr_pend = 0;
            end
            if (rd_pend) begin
                check("rvalid_after_last", {axi.axi_rvalid, axi.axi_rlast}, 0);
                exp_rd = (exp_rd + 1) % 65536;
                rd_pend = 0;
            end
            check("wr_bursts", axi.wr_bursts, exp_wr);
            check("rd_bursts", axi.rd_bursts, exp_rd);
            check("wlast_gated", axi.axi_wusero_last & ~axi.axi_wready, 0);
            check("rlast_gated", axi.axi_rlast & ~axi.axi_rvalid, 0);
            if (axi.axi_wready) begin
                mon_idx = (cur_wbase + w_seen) % DEPTH;
                m_mem[mon_idx]   = axi.axi_wdata;
                m_known[mon_idx] = 1;
                check("wusero_last", axi.axi_wusero_last, w_seen == cur_wlen);
                if (w_seen >= cur_wlen) begin wr_pend = 1; w_seen = 0; end
                else w_seen++;
            end
            if (axi.axi_rvalid) begin
                mon_idx = (cur_rbase + r_seen) % DEPTH;
                if (m_known[mon_idx]) check("rdata", axi.axi_rdata, m_mem[mon_idx]);
                check("rlast", axi.axi_rlast, r_seen == cur_rlen);
                if (r_seen == 0) first_rdata = axi.axi_rdata;
                last_rdata = axi.axi_rdata;
                if (r_seen >= cur_rlen) begin rd_pend = 1; r_seen = 0; end
                else r_seen++;
            end
        end
    end

    task automatic do_write(input logic [AW-1:0] addr, input int len, input int abort_at);
        int n, beat, first, wcyc;
        bit ar_seen, acc;
        cur_wbase = int'(addr >> 3) % DEPTH;
        cur_wlen  = len;
        axi.axi_awaddr  = addr;
        axi.axi_awlen   = 4'(len);
        axi.axi_awvalid = 1'b1;
        axi.axi_wdata   = wbuf[0];
        n = 0;
        do begin @(negedge core_clk); n++; end while (!axi.axi_awready && n < 20);
        check("aw_handshake", axi.axi_awready, 1);
        @(posedge core_clk); #1;
        axi.axi_awvalid = 1'b0;
        n = 0; beat = 0; first = -1; wcyc = 0; ar_seen = 0;
        while (beat <= len && n < 200) begin
            @(negedge core_clk); n++;
            if (n == 1) check("awready_pulse", axi.axi_awready, 0);
            ar_seen |= axi.axi_arready;
            acc = axi.axi_wready;
            if (acc) begin if (first < 0) first = n; wcyc = n; end
            @(posedge core_clk); #1;
            if (acc) begin
                beat++;
                if (beat < 16) axi.axi_wdata = wbuf[beat];
            end
            if (abort_at >= 0 && beat == abort_at) begin
                core_clk_rst_n = 1'b0;
                @(posedge core_clk); #1;
                core_clk_rst_n = 1'b1;
                return;
            end
        end
        check("w_beats", beat, len + 1);
        check("ar_blocked_during_write", ar_seen, 0);
`ifndef DDR_RESP_BP_EN
        check("wready_start", first, 1);
        check("wready_contiguous", wcyc - first + 1, len + 1);
`else
        if (len == 15) check("write_stalls_seen", (wcyc - first + 1) > 16, 1);
`endif
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int len);
        int n, first, beats;
        bit seen_last;
        cur_rbase = int'(addr >> 3) % DEPTH;
        cur_rlen  = len;
        axi.axi_araddr  = addr;
        axi.axi_arlen   = 4'(len);
        axi.axi_arvalid = 1'b1;
        n = 0;
        do begin @(negedge core_clk); n++; end while (!axi.axi_arready && n < 100);
        check("ar_handshake", axi.axi_arready, 1);
        @(posedge core_clk); #1;
        axi.axi_arvalid = 1'b0;
        n = 0; first = -1; beats = 0; seen_last = 0;
        while (!seen_last && n < 300) begin
            @(negedge core_clk); n++;
            if (n == 1) check("arready_pulse", axi.axi_arready, 0);
            if (axi.axi_rvalid) begin
                beats++;
                if (first < 0) first = n;
                seen_last = axi.axi_rlast;
            end
        end
        @(posedge core_clk); #1;
        check("r_beats", beats, len + 1);
`ifndef DDR_RESP_BP_EN
        check("rvalid_latency", first, 3);
        check("rvalid_contiguous", n - first + 1, len + 1);
`else
        if (len == 15) check("read_stalls_seen", (n - first + 1) > 16, 1);
`endif
    endtask

    function automatic logic [BW-1:0] rand_beat();
        logic [BW-1:0] v;
        for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [AW-1:0] beat_addr(input int idx);
        logic [AW-1:0] a;
        a = AW'($urandom);
        a[8:3] = 6'(idx);
        return a;
    endfunction

    initial begin
        axi.axi_awaddr = '0; axi.axi_awlen = '0; axi.axi_awvalid = 1'b0; axi.axi_wdata = '0;
        axi.axi_araddr = '0; axi.axi_arlen = '0; axi.axi_arvalid = 1'b0;
        repeat (3) @(posedge core_clk);
        #1 core_clk_rst_n = 1'b1;
        @(negedge core_clk);

        for (int i = 0; i < 16; i++) wbuf[i] = BW'(i + 1);
        do_write(AW'(0), 15, -1);
        @(negedge core_clk);
        check("wr_bursts_lit", axi.wr_bursts, 1);
        do_read(AW'(0), 15);
        @(negedge core_clk);
        check("rd_bursts_lit", axi.rd_bursts, 1);
        check("rdata_first_lit", first_rdata, 1);
        check("rdata_last_lit", last_rdata, 16);

        for (int i = 0; i < 4; i++) wbuf[i] = BW'(32'h100 + i);
        axi.axi_araddr = AW'(20 << 3); axi.axi_arlen = 4'd3; axi.axi_arvalid = 1'b1;
        do_write(AW'(20 << 3), 3, -1);
        do_read(AW'(20 << 3), 3);
        @(negedge core_clk);
        check("sim_first_lit", first_rdata, 32'h100);
        check("sim_last_lit", last_rdata, 32'h103);
        check("sim_counts_lit", {axi.wr_bursts, axi.rd_bursts}, {16'd2, 16'd2});

        for (int i = 0; i < 4; i++) wbuf[i] = BW'(32'hA + i);
        do_write(beat_addr(62), 3, -1);
        do_read(beat_addr(0), 1);
        check("wrap_first_lit", first_rdata, 32'hC);
        check("wrap_last_lit", last_rdata, 32'hD);
        do_read(beat_addr(62), 3);
        check("wrap_top_lit", first_rdata, 32'hA);

        for (int i = 0; i < 16; i++) wbuf[i] = BW'(32'h200 + i);
        do_write(AW'(0), 15, 5);
        @(negedge core_clk);
        do_read(AW'(0), 5);
        @(negedge core_clk);
        check("rst_first_lit", first_rdata, 32'h200);
        check("rst_untouched_lit", last_rdata, 6);
        check("rst_counts_lit", {axi.wr_bursts, axi.rd_bursts}, {16'd0, 16'd1});

        repeat (40) begin
            repeat ($urandom_range(0, 3)) @(posedge core_clk);
            #1;
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) wbuf[i] = rand_beat();
                do_write(AW'($urandom), $urandom_range(0, 15), -1);
            end else begin
                do_read(AW'($urandom), $urandom_range(0, 15));
            end
        end
        repeat (2) @(negedge core_clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/ddr_axi_resp_mem.md
Name: ddr_axi_resp_mem

Overview:
- Responder end of the simplified DDR AXI burst interface. It accepts the write-address, write-data and read-address channels that our DDR traffic generators drive, and returns read data.
- Backs each burst with an internal synchronous RAM of 2^DEPTH_AW beats.
- Used as a simulation and bring-up stand-in for the DDR controller, so initiators can be exercised before ddr_init_done exists.
- Serves one burst at a time: write or read, never both.

Parameters:
- CTRL_ADDR_WIDTH, 28: width of axi_awaddr / axi_araddr.
- MEM_DQ_WIDTH, 32: DQ width. A data beat is MEM_DQ_WIDTH*8 bits.
- DEPTH_AW, 6: log2 of RAM depth in beats (64 beats).
- ADDR_LSB, 3: address LSBs dropped to form the beat index. One beat spans 8 DQ-word addresses.

Ports:
- core_clk  in  1  single clock for all logic.
- core_clk_rst_n  in  1  reset, synchronous, active-low.
- axi_awaddr  in  CTRL_ADDR_WIDTH  write burst start address.
- axi_awlen  in  4  write beats minus 1.
- axi_awvalid  in  1  write address valid.
- axi_awready  out  1  write address accept.
- axi_wdata  in  MEM_DQ_WIDTH*8  write beat data.
- axi_wready  out  1  beat accepted this cycle.
- axi_wusero_last  out  1  high with axi_wready on the final write beat.
- axi_araddr  in  CTRL_ADDR_WIDTH  read burst start address.
- axi_arlen  in  4  read beats minus 1.
- axi_arvalid  in  1  read address valid.
- axi_arready  out  1  read address accept.
- axi_rdata  out  MEM_DQ_WIDTH*8  read beat data.
- axi_rvalid  out  1  read beat valid. There is no rready; the initiator always accepts.
- axi_rlast  out  1  high with axi_rvalid on the final read beat.
- wr_bursts  out  16  count of completed write bursts; wraps.
- rd_bursts  out  16  count of completed read bursts; wraps.

Behaviour:
- Reset:
  - All outputs are registered, so every output is 0 on reset. This includes axi_rdata, both counters and the FSM, which returns to S_IDLE.
  - RAM contents are not cleared.
  - Reset asserted mid-burst abandons the burst at the next edge, and no further RAM writes occur.
- State machine states: S_IDLE, S_AW_ACK, S_WDATA, S_AR_ACK, S_RDATA.
- S_IDLE:
  - If axi_awvalid is high, go to S_AW_ACK.
  - Else if axi_arvalid is high, go to S_AR_ACK.
  - If both are high on the same cycle, the write wins. axi_arvalid stays pending and is served after the write completes.
- S_AW_ACK:
  - axi_awready is 1.
  - On axi_awvalid && axi_awready:
    - latch base = axi_awaddr[ADDR_LSB+DEPTH_AW-1:ADDR_LSB] and len = axi_awlen;
    - clear cnt;
    - drop axi_awready;
    - go to S_WDATA.
  - If axi_awvalid falls before the handshake, return to S_IDLE without accepting.
- S_WDATA:
  - axi_wready is high from the cycle after the handshake.
  - Every cycle with axi_wready high:
    - RAM[(base+cnt) mod 2^DEPTH_AW] <= axi_wdata;
    - cnt increments.
  - axi_wusero_last = 1 exactly on the beat where cnt == len.
  - The next cycle: axi_wready is 0, wr_bursts increments, state goes to S_IDLE.
  - A burst of len+1 beats holds axi_wready high for len+1 cycles (without backpressure).
- S_AR_ACK / S_RDATA:
  - The read side mirrors the write side: axi_arready, then latch base/len on the handshake.
  - The RAM has a 1-cycle synchronous read. The first axi_rvalid appears 2 cycles after the ar handshake edge.
  - Beats are contiguous, one per cycle.
  - axi_rlast is asserted with the final beat.
  - The cycle after the last beat: rvalid and rlast are 0, rd_bursts increments, state goes to S_IDLE.
  - axi_rdata holds its last value when axi_rvalid is 0.
- Address wrap: a burst crossing the top of the RAM wraps to beat 0. Address bits above the beat index are ignored.
- Read-after-write: a read issued after a write completes returns the newly written data. There is no overlap hazard because bursts are serialized.
- Minimum turnaround: 1 idle cycle between bursts.

Optional Feature:
- DDR_RESP_BP_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5, loaded on reset) advances every cycle.
  - In S_WDATA or S_RDATA, a cycle with lfsr[0]==1 is a stall: axi_wready (or axi_rvalid) is 0, there is no RAM write/read advance, and cnt holds.
  - axi_wusero_last and axi_rlast only ever assert together with their valid/ready.
  - Beat count and data order are unchanged.
- Undefined: no LFSR logic; data phases are stall-free as described above.

Decomposition:
- Package ddr_resp_pkg holds:
  - the FSM state encodings (one-hot, 5 bits);
  - LFSR seed and tap constants;
  - the beat-width localparam MEM_DQ_WIDTH*8.
- One sub-module: ddr_resp_ram, a single-port RAM with synchronous write and registered read, parameterized by DEPTH_AW and data width. Top-level FSM and counters stay in ddr_axi_resp_mem.

Test Plan:
- Write awaddr=0, awlen=15, wdata=1..16 -> awready pulses 1 cycle; wready high 16 cycles; wusero_last only on beat 16; wr_bursts=1.
- Read araddr=0, arlen=15 after that write -> rvalid 16 contiguous cycles starting 2 cycles after handshake; rdata=1..16; rlast on 16th; rd_bursts=1.
- awvalid and arvalid raised same cycle -> write served first; read handshake follows; read returns written data.
- Write awaddr=62<<3, awlen=3, data A,B,C,D -> beats land at indices 62,63,0,1; read of araddr=0, arlen=1 returns C,D.
- core_clk_rst_n low for 1 cycle at beat 5 of a 16-beat write -> next cycle all outputs are 0 and state is S_IDLE; a following read of beats 0-4 returns the first 5 values.
- With DDR_RESP_BP_EN: 16-beat write then read -> stalls observed, exactly 16 wready and 16 rvalid beats, data matches 1..16.
